// File: rtl/vga_scan_ctrl.sv
// Scan timing controller for the background/UI renderer: 640x480@60 counters,
// renderer coordinates, latency-matched sync/DE and blanked RGB to the DAC.
module vga_scan_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIX_DIV    = 4,
  parameter int RENDER_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start,
  output logic       busy
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);
  localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
  localparam logic [10:0]   H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0]   HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0]   VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]    INACT   = 3'b011;  // {de, hs, vs}

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
    $error("vga_scan_ctrl: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
  if (PIX_DIV < 1 || PIX_DIV > 16 || RENDER_LAT < 0 || RENDER_LAT > 4) begin : g_param_chk
    $error("vga_scan_ctrl: PIX_DIV or RENDER_LAT out of range");
  end

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div;
  logic [9:0]      hcnt, vcnt;
  logic            pix_tick, h_end, v_end, frame_end;
  logic [2:0]      raw, dly_out;
  logic [10:0]     hc11, vc11;

  assign pix_tick  = (state != IDLE) && (div == DIV_MAX);
  assign h_end     = (hcnt == H_MAX);
  assign v_end     = (vcnt == V_MAX);
  assign frame_end = pix_tick && h_end && v_end;

  assign x    = hcnt;
  assign y    = vcnt;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (run) state_nxt = RUN;
      RUN:      if (!run) state_nxt = STOPPING;
      STOPPING: if (run) state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        div  <= '0;
        hcnt <= '0;
        vcnt <= '0;
      end else begin
        div <= pix_tick ? '0 : div + 1'b1;
        if (pix_tick) begin
          hcnt <= h_end ? '0 : hcnt + 10'd1;
          if (h_end) vcnt <= v_end ? '0 : vcnt + 10'd1;
        end
      end
      // a stop-completing wrap lands in IDLE and is not a new frame
      frame_start <= frame_end && (state_nxt != IDLE);
    end
  end

  assign hc11 = {1'b0, hcnt};
  assign vc11 = {1'b0, vcnt};

  always_comb begin
    raw = INACT;
    if (state != IDLE) begin
      raw[2] = (hc11 < H_ACT) && (vc11 < V_ACT);
      raw[1] = !((hc11 >= HS_BEG) && (hc11 < HS_END));
      raw[0] = !((vc11 >= VS_BEG) && (vc11 < VS_END));
    end
  end

  if (RENDER_LAT == 0) begin : g_no_dly
    assign dly_out = raw;
  end else begin : g_dly
    logic [RENDER_LAT-1:0][2:0] dly_pipe;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_pipe <= {RENDER_LAT{INACT}};
      end else begin
        dly_pipe[0] <= raw;
        for (int i = 1; i < RENDER_LAT; i++) dly_pipe[i] <= dly_pipe[i-1];
      end
    end
    assign dly_out = dly_pipe[RENDER_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      de    <= dly_out[2];
      hsync <= dly_out[1];
      vsync <= dly_out[0];
      r     <= dly_out[2] ? in_r : 8'd0;
      g     <= dly_out[2] ? in_g : 8'd0;
      b     <= dly_out[2] ? in_b : 8'd0;
    end
  end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: two shrunken-timing instances (PIX_DIV=2/LAT=1 and
// PIX_DIV=1/LAT=0) checked every clk against a clock-count scan model.
module tb_vga_scan_ctrl;
  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;  // 15
  localparam int VT = VA + VF + VSW + VB;  // 8

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] x0, y0, x1, y1;
  logic [7:0] ir0, ig0, ib0, ir1, ig1, ib1, r0, g0, b0, r1, g1, b1;
  logic       hs0, vs0, de0, fs0, bz0, hs1, vs1, de1, fs1, bz1;

  vga_scan_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                  .PIX_DIV(2), .RENDER_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .run(run), .x(x0), .y(y0),
    .in_r(ir0), .in_g(ig0), .in_b(ib0), .r(r0), .g(g0), .b(b0),
    .hsync(hs0), .vsync(vs0), .de(de0), .frame_start(fs0), .busy(bz0));

  vga_scan_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                  .PIX_DIV(1), .RENDER_LAT(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run(run), .x(x1), .y(y1),
    .in_r(ir1), .in_g(ig1), .in_b(ib1), .r(r1), .g(g1), .b(b1),
    .hsync(hs1), .vsync(vs1), .de(de1), .frame_start(fs1), .busy(bz1));

  // renderers: one registered stage for instance 0, combinational for instance 1
  always_ff @(posedge clk) begin
    ir0 <= x0[7:0];
    ig0 <= y0[7:0];
    ib0 <= x0[7:0] ^ y0[7:0];
  end
  assign ir1 = x1[7:0];
  assign ig1 = y1[7:0];
  assign ib1 = x1[7:0] ^ y1[7:0];

  int checks = 0, errors = 0;

  // reference model: scan position is simply elapsed clks since start / PIX_DIV
  bit mb[2], ms[2], mfs[2];
  int mt[2], mx[2], my[2], n[2];
  int hx[2][8], hy[2][8];
  bit hb[2][8];

  function automatic int pd(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int lat(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mb[i] = 0; ms[i] = 0; mfs[i] = 0;
      mt[i] = 0; mx[i] = 0; my[i] = 0; n[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int fl, p;
    bit e;
    fl = pd(i) * HT * VT;
    mfs[i] = 0;
    if (!mb[i]) begin
      if (run) begin mb[i] = 1; mt[i] = 0; ms[i] = 0; end
    end else begin
      e = (mt[i] % fl) == fl - 1;
      if (ms[i] && !run && e) begin
        mb[i] = 0; mt[i] = 0; ms[i] = 0;
      end else begin
        mt[i]++; mfs[i] = e; ms[i] = !run;
      end
    end
    p = mt[i] / pd(i);
    mx[i] = p % HT;
    my[i] = (p / HT) % VT;
    n[i]++;
    hx[i][n[i] % 8] = mx[i];
    hy[i][n[i] % 8] = my[i];
    hb[i][n[i] % 8] = mb[i];
  endtask

  task automatic check_inst(input int i);
    logic [48:0] got, exp;
    int k, bx, by;
    bit bb, e_de, e_hs, e_vs;
    got = (i == 0) ? {x0, y0, bz0, fs0, de0, hs0, vs0, r0, g0, b0}
                   : {x1, y1, bz1, fs1, de1, hs1, vs1, r1, g1, b1};
    k = n[i] - lat(i) - 1;
    bb = 0; bx = 0; by = 0;
    if (k >= 1) begin bx = hx[i][k % 8]; by = hy[i][k % 8]; bb = hb[i][k % 8]; end
    e_de = bb && bx < HA && by < VA;
    e_hs = !(bb && bx >= HA + HF && bx < HA + HF + HSW);
    e_vs = !(bb && by >= VA + VF && by < VA + VF + VSW);
    exp = {10'(mx[i]), 10'(my[i]), mb[i], mfs[i], e_de, e_hs, e_vs,
           e_de ? 8'(bx) : 8'd0, e_de ? 8'(by) : 8'd0, e_de ? 8'(bx ^ by) : 8'd0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL scan%0d t=%0t {x,y,busy,fs,de,hs,vs,rgb} got=%h exp=%h", i, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check_inst(0);
    check_inst(1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin model_step(0); model_step(1); end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    model_reset();
    repeat (3) begin @(negedge clk); check_all(); end
    rst_n = 1'b1;
  endtask

  task automatic tick_until_y(input int yv, input int lim);
    int c;
    c = 0;
    while (my[0] != yv && c < lim) begin tick(); c++; end
    checks++;
    if (my[0] != yv) begin
      errors++;
      $display("FAIL wait_y%0d timed out after %0d clks", yv, lim);
    end
  endtask

  typedef struct {
    bit run; int ncyc;
    int ex; int ey; bit eb; bit efs;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int c, fsn, gaps;
    vecs[0] = '{1'b1,   1,  0, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b1,   3,  1, 0, 1'b1, 1'b0};
    vecs[2] = '{1'b1,  30, 14, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b1,  31,  0, 1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 240, 14, 7, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 241,  0, 0, 1'b1, 1'b1};
    vecs[6] = '{1'b0,  50,  0, 0, 1'b0, 1'b0};

    do_reset();
    repeat (20) tick();

    for (int v = 0; v < 7; v++) begin
      do_reset();
      run = vecs[v].run;
      repeat (vecs[v].ncyc) tick();
      checks++;
      if ({x0, y0, bz0, fs0} !== {10'(vecs[v].ex), 10'(vecs[v].ey), vecs[v].eb, vecs[v].efs}) begin
        errors++;
        $display("FAIL vec%0d {x,y,busy,fs} got=%0d,%0d,%b,%b exp=%0d,%0d,%b,%b", v,
                 x0, y0, bz0, fs0, vecs[v].ex, vecs[v].ey, vecs[v].eb, vecs[v].efs);
      end
      run = 1'b0;
    end

    do_reset();
    repeat (100) tick();

    // stop: drop run mid-frame, scan must run to frame end with no frame_start
    do_reset();
    run = 1'b1;
    tick_until_y(2, 1000);
    run = 1'b0;
    c = 0; fsn = 0;
    while (bz0 && c < 1000) begin tick(); if (fs0) fsn++; c++; end
    checks++;
    if (bz0 || fsn != 0 || x0 != 0 || y0 != 0) begin
      errors++;
      $display("FAIL stop busy=%b frame_starts=%0d x=%0d y=%0d exp busy=0 fs=0 x=0 y=0",
               bz0, fsn, x0, y0);
    end

    // restart while stopping: no gap in busy
    run = 1'b1;
    tick_until_y(1, 1000);
    run = 1'b0;
    tick_until_y(3, 1000);
    run = 1'b1;
    gaps = 0;
    repeat (300) begin tick(); if (!bz0) gaps++; end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL restart idle_clks got=%0d exp=0", gaps);
    end

    repeat (2000) begin
      if ($urandom_range(63) == 0) run = !run;
      tick();
    end

    // async reset while vsync is asserted
    run = 1'b1;
    c = 0;
    while (vs0 && c < 600) begin tick(); c++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vs0 !== 1'b1 || de0 !== 1'b0 || hs0 !== 1'b1 || bz0 !== 1'b0 || x0 !== 10'd0 || y0 !== 10'd0 || c >= 600) begin
      errors++;
      $display("FAIL async_rst vs=%b de=%b hs=%b busy=%b x=%0d y=%0d waited=%0d exp vs=1 de=0 hs=1 busy=0 x=0 y=0",
               vs0, de0, hs0, bz0, x0, y0, c);
    end
    run = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
